// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code stream pipeline.
// Helpers work on 32-bit zero-extended words so any width up to 32 can reuse them.
package gray_pkg;

  localparam int unsigned GrayWidth = 3;

  typedef enum logic [1:0] {
    StUnsync,
    StLocked,
    StLost
  } track_state_e;

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  function automatic logic [5:0] popcount(input logic [31:0] value);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 6'(value[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_skid_fifo.sv
// Two-entry valid/ready FIFO; in_ready_o depends only on registered occupancy.
module gray_skid_fifo #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;
  logic             push, pop;

  always_comb begin
    in_ready_o  = (count_q != 2'd2);
    out_valid_o = (count_q != 2'd0);
    out_data_o  = mem_q[rd_ptr_q];
    push        = in_valid_i && in_ready_o;
    pop         = out_valid_o && out_ready_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/gray_stream_checker.sv
// Sink for a Gray-coded stream: decodes to binary, flags multi-bit steps,
// tracks lock state and buffers decoded words in a 2-entry FIFO.
module gray_stream_checker
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH     = GrayWidth,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_gray,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_bin,
  output logic                 out_step_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 sync_lost
);

  track_state_e         state_q, state_d;
  logic [WIDTH-1:0]     prev_gray_q, prev_gray_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 err_run_q, err_run_d;
  logic                 good_run_q, good_run_d;

  logic                 accept;
  logic                 step_err;
  logic [5:0]           step_dist;
  logic [WIDTH-1:0]     word_bin;

  always_comb begin
    accept    = in_valid && in_ready;
    word_bin  = WIDTH'(gray2bin(32'(in_gray)));
    step_dist = popcount(32'(in_gray ^ prev_gray_q));
    // clear makes the concurrent word the unchecked first word
    step_err  = accept && !clear && (state_q != StUnsync) && (step_dist >= 6'd2);
  end

  always_comb begin
    state_d     = state_q;
    prev_gray_d = prev_gray_q;
    err_count_d = err_count_q;
    err_run_d   = err_run_q;
    good_run_d  = good_run_q;
    if (clear) begin
      state_d     = accept ? StLocked : StUnsync;
      err_count_d = '0;
      err_run_d   = 1'b0;
      good_run_d  = 1'b0;
      if (accept) prev_gray_d = in_gray;
    end else if (accept) begin
      prev_gray_d = in_gray;
      if (step_err && (err_count_q != '1)) begin
        err_count_d = err_count_q + ERR_CNT_W'(1);
      end
      unique case (state_q)
        StUnsync: begin
          state_d    = StLocked;
          err_run_d  = 1'b0;
          good_run_d = 1'b0;
        end
        StLocked: begin
          if (step_err && err_run_q) begin
            state_d    = StLost;
            err_run_d  = 1'b0;
            good_run_d = 1'b0;
          end else begin
            err_run_d = step_err;
          end
        end
        StLost: begin
          if (step_err) begin
            good_run_d = 1'b0;
          end else if (good_run_q) begin
            state_d    = StLocked;
            good_run_d = 1'b0;
          end else begin
            good_run_d = 1'b1;
          end
        end
        default: state_d = StUnsync;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StUnsync;
      prev_gray_q <= '0;
      err_count_q <= '0;
      err_run_q   <= 1'b0;
      good_run_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_gray_q <= prev_gray_d;
      err_count_q <= err_count_d;
      err_run_q   <= err_run_d;
      good_run_q  <= good_run_d;
    end
  end

  assign err_count = err_count_q;
  assign sync_lost = (state_q == StLost);

  gray_skid_fifo #(
    .Width(WIDTH + 1)
  ) u_out_fifo (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  ({word_bin, step_err}),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o ({out_bin, out_step_err})
  );

endmodule
